// File: rtl/pht_update_queue.sv
// Write side of the gshare PHT: computes index and next counter value for each resolved
// conditional branch, queues the pairs and drains them into the PHT write port when free.
module pht_update_queue #(
  parameter int unsigned PC_WIDTH            = 32,
  parameter int unsigned INSN_ADDR_BIT_WIDTH = 2,
  parameter int unsigned GHR_WIDTH           = 10,
  parameter int unsigned PHT_ENTRY_NUM       = 2048,
  parameter int unsigned QUEUE_SIZE          = 32,
  localparam int unsigned IDX_W              = $clog2(PHT_ENTRY_NUM),
  localparam int unsigned PTR_W              = $clog2(QUEUE_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 brValid,
  input  logic [PC_WIDTH-1:0]  brAddr,
  input  logic                 brExecTaken,
  input  logic                 brIsCondBr,
  input  logic [GHR_WIDTH-1:0] brGlobalHistory,
  input  logic [1:0]           brPhtPrevValue,
  input  logic                 phtWriteStall,
  output logic                 phtWE,
  output logic [IDX_W-1:0]     phtWA,
  output logic [1:0]           phtWV,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_W:0]       count,
  output logic [15:0]          dropCount
);

  localparam int unsigned EntW = IDX_W + 2;

  logic [IDX_W-1:0] ghr_idx;
  logic [IDX_W-1:0] new_idx;
  logic [1:0]       new_val;
  logic             push_req;
  logic             push_ok;
  logic             drop;
  logic             pop;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [15:0]      drop_q, drop_d;
  logic [EntW-1:0]  mem [QUEUE_SIZE];
  logic [EntW-1:0]  head_ent;

  // History is zero-extended or truncated (LSBs kept) to the index width.
  if (GHR_WIDTH >= IDX_W) begin : g_ghr_trunc
    assign ghr_idx = brGlobalHistory[IDX_W-1:0];
  end else begin : g_ghr_ext
    assign ghr_idx = {{(IDX_W - GHR_WIDTH){1'b0}}, brGlobalHistory};
  end

  logic unused_inputs;
  assign unused_inputs = ^{brAddr, brGlobalHistory};

  assign new_idx = brAddr[INSN_ADDR_BIT_WIDTH +: IDX_W] ^ ghr_idx;

  always_comb begin
    new_val = brPhtPrevValue;
    if (brExecTaken && brPhtPrevValue != 2'd3) begin
      new_val = brPhtPrevValue + 2'd1;
    end else if (!brExecTaken && brPhtPrevValue != 2'd0) begin
      new_val = brPhtPrevValue - 2'd1;
    end
  end

  assign full  = (count_q == (PTR_W+1)'(QUEUE_SIZE));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dropCount = drop_q;

  // Gated by rst so a reset cycle never issues a write from discarded entries.
  assign pop   = !empty && !phtWriteStall && !rst;
  assign phtWE = pop;

  // Saturated results are filtered out: they would not change the PHT.
  assign push_req = brValid && brIsCondBr && (new_val != brPhtPrevValue) && !rst;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign head_ent = mem[head_q];
  assign phtWA    = empty ? '0 : head_ent[EntW-1:2];
  assign phtWV    = empty ? '0 : head_ent[1:0];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push_ok) begin
      tail_d = tail_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
    if (drop && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail_q] <= {new_idx, new_val};
    end
  end

endmodule

// File: tb/tb_pht_update_queue.sv
// Scoreboard bench for pht_update_queue: expected PHT writes are queued on drive and
// compared in order as the DUT issues them.
module tb_pht_update_queue;

  localparam int QS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        brValid;
  logic [31:0] brAddr;
  logic        brExecTaken;
  logic        brIsCondBr;
  logic [9:0]  brGlobalHistory;
  logic [1:0]  brPhtPrevValue;
  logic        phtWriteStall;
  logic        phtWE;
  logic [10:0] phtWA;
  logic [1:0]  phtWV;
  logic        full;
  logic        empty;
  logic [5:0]  count;
  logic [15:0] dropCount;

  typedef struct packed {
    logic [10:0] idx;
    logic [1:0]  val;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mdrop = 0;
  int   nwrites = 0;
  int   npush = 0;

  always #5 clk = ~clk;

  pht_update_queue dut (
    .clk             (clk),
    .rst             (rst),
    .brValid         (brValid),
    .brAddr          (brAddr),
    .brExecTaken     (brExecTaken),
    .brIsCondBr      (brIsCondBr),
    .brGlobalHistory (brGlobalHistory),
    .brPhtPrevValue  (brPhtPrevValue),
    .phtWriteStall   (phtWriteStall),
    .phtWE           (phtWE),
    .phtWA           (phtWA),
    .phtWV           (phtWV),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .dropCount       (dropCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] m_idx(input logic [31:0] a, input logic [9:0] g);
    return a[12:2] ^ {1'b0, g};
  endfunction

  function automatic logic [1:0] m_new(input logic t, input logic [1:0] p);
    if (t) return (p == 2'd3) ? 2'd3 : p + 2'd1;
    return (p == 2'd0) ? 2'd0 : p - 2'd1;
  endfunction

  // One cycle: drive inputs just after the edge, check outputs at negedge, update model.
  task automatic step(input logic v, input logic c, input logic [31:0] a, input logic t,
                      input logic [9:0] g, input logic [1:0] p, input logic st, input logic r);
    logic exp_we;
    int   sz;
    ent_t e;
    rst = r;
    brValid = v;
    brIsCondBr = c;
    brAddr = a;
    brExecTaken = t;
    brGlobalHistory = g;
    brPhtPrevValue = p;
    phtWriteStall = st;
    @(negedge clk);
    sz = exp_q.size();
    exp_we = !r && sz != 0 && !st;
    check("count", 32'(count), 32'(sz));
    check("full", 32'(full), 32'(sz == QS));
    check("empty", 32'(empty), 32'(sz == 0));
    check("drop", 32'(dropCount), 32'(mdrop));
    check("we", 32'(phtWE), 32'(exp_we));
    check("cnt_max", 32'(count <= 6'd32), 32'd1);
    if (sz == 0) begin
      check("wa_mask", 32'(phtWA), 32'd0);
      check("wv_mask", 32'(phtWV), 32'd0);
    end else begin
      // Head is visible even while stalled.
      e = exp_q[0];
      check("wa", 32'(phtWA), 32'(e.idx));
      check("wv", 32'(phtWV), 32'(e.val));
    end
    if (exp_we) begin
      void'(exp_q.pop_front());
      nwrites++;
    end
    if (r) begin
      exp_q.delete();
      mdrop = 0;
    end else if (v && c && m_new(t, p) != p) begin
      if (exp_q.size() < QS) begin
        exp_q.push_back('{idx: m_idx(a, g), val: m_new(t, p)});
        npush++;
      end else if (mdrop < 65535) begin
        mdrop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 32'h0, 1'b0, 10'h0, 2'd0, st, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    brValid = 1'b0;
    brIsCondBr = 1'b0;
    brAddr = '0;
    brExecTaken = 1'b0;
    brGlobalHistory = '0;
    brPhtPrevValue = '0;
    phtWriteStall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic push, write next cycle, then empty.
    step(1'b1, 1'b1, 32'h0000_1008, 1'b1, 10'h005, 2'd1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Saturation filter and non-conditional results.
    step(1'b1, 1'b1, 32'h0000_2000, 1'b1, 10'h0aa, 2'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_2004, 1'b0, 10'h055, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_2008, 1'b1, 10'h011, 2'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_200c, 1'b1, 10'h022, 2'd1, 1'b0, 1'b0);
    idle(1'b0);

    // Fill under stall, overflow once, then push+pop while full, then drain.
    for (int i = 0; i < QS; i++) begin
      step(1'b1, 1'b1, 32'h100 + 32'(i) * 4, 1'b1, 10'(i * 7), 2'(i % 3), 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 32'h0000_4000, 1'b0, 10'h3ff, 2'd2, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 1'b1, 32'h0000_5550, 1'b0, 10'h123, 2'd3, 1'b0, 1'b0);
    repeat (36) idle(1'b0);
    check("fill_writes", 32'(nwrites), 32'(npush));

    // Random traffic with toggling stall.
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 1)), 10'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (36) idle(1'b0);

    // Reset mid-operation discards pending entries.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 32'h800 + 32'(i) * 4, 1'b0, 10'(i), 2'd2, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 32'h0000_9000, 1'b1, 10'h001, 2'd1, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 1'b1, 32'h0000_a00c, 1'b1, 10'h2c3, 2'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);

    check("final_empty", 32'(exp_q.size()), 32'd0);
    check("total_writes", 32'(nwrites), 32'(npush - 10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
